// File: rtl/fcl_result_streamer_if.sv
// ---------------------------------------------------------------------------
// fcl_result_streamer_if
// Valid/ready result stream carrying one neuron value per beat.
//   m_valid  : beat valid (driven by the streamer)
//   m_ready  : downstream accepts beat (driven by the consumer)
//   m_data   : neuron value, DATA_W bits, signed two's complement
//   m_index  : neuron index of the current beat, IDX_W bits
//   m_last   : high on the beat carrying the final neuron of the layer
// ---------------------------------------------------------------------------
interface fcl_result_streamer_if #(
    parameter int DATA_W = 16,
    parameter int IDX_W  = 6
) ();
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic [IDX_W-1:0]  m_index;
    logic              m_last;

    modport master (
        output m_valid, m_data, m_index, m_last,
        input  m_ready
    );

    modport slave (
        input  m_valid, m_data, m_index, m_last,
        output m_ready
    );
endinterface

// File: rtl/fcl_result_streamer.sv
// ---------------------------------------------------------------------------
// fcl_result_streamer
// Captures the FCL controller's parallel result vector on its done pulse and
// drains it as a stream of one neuron per beat (optionally ReLU'd), while
// tracking the argmax of the pre-ReLU values over the layer.
//   clk          : rising-edge clock
//   rst_n        : asynchronous active-low reset
//   layer_done   : 1-cycle pulse, layer_out valid this cycle
//   layer_out    : NEURON_COUNT x DATA_W parallel results
//   m            : result stream (master side of fcl_result_streamer_if)
//   busy         : high while streaming or reporting
//   argmax_idx   : index of the largest pre-ReLU value of the last layer
//   argmax_valid : 1-cycle pulse when argmax_idx updates
//   overrun      : sticky, a layer_done arrived while busy
// ---------------------------------------------------------------------------
module fcl_result_streamer #(
    parameter  int NEURON_COUNT = 50,
    parameter  int DATA_W       = 16,
    parameter  int RELU_EN      = 1,
    localparam int IDX_W        = $clog2(NEURON_COUNT)
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 layer_done,
    input  logic [NEURON_COUNT-1:0][DATA_W-1:0]  layer_out,
    fcl_result_streamer_if.master                m,
    output logic                                 busy,
    output logic [IDX_W-1:0]                     argmax_idx,
    output logic                                 argmax_valid,
    output logic                                 overrun
);
    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_REPORT} state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NEURON_COUNT - 1);

    function automatic logic [DATA_W-1:0] relu_f(input logic [DATA_W-1:0] x);
        if ((RELU_EN != 0) && x[DATA_W-1]) return '0;
        return x;
    endfunction

    state_t                               state_q, state_d;
    logic [NEURON_COUNT-1:0][DATA_W-1:0]  snap_q, snap_d;
    logic [IDX_W-1:0]                     idx_q, idx_d;
    logic signed [DATA_W-1:0]             best_q, best_d;
    logic [IDX_W-1:0]                     best_idx_q, best_idx_d;
    logic                                 m_valid_q, m_valid_d;
    logic [DATA_W-1:0]                    m_data_q, m_data_d;
    logic                                 m_last_q, m_last_d;
    logic [IDX_W-1:0]                     argmax_idx_q, argmax_idx_d;
    logic                                 argmax_valid_q, argmax_valid_d;
    logic                                 overrun_q, overrun_d;

    logic                                 xfer;
    logic [IDX_W-1:0]                     nxt_idx;
    logic signed [DATA_W-1:0]             cand;
    logic                                 take;
    logic signed [DATA_W-1:0]             best_n;
    logic [IDX_W-1:0]                     best_idx_n;

    assign xfer = m_valid_q && m.m_ready;

    always_comb begin
        state_d        = state_q;
        snap_d         = snap_q;
        idx_d          = idx_q;
        best_d         = best_q;
        best_idx_d     = best_idx_q;
        m_valid_d      = m_valid_q;
        m_data_d       = m_data_q;
        m_last_d       = m_last_q;
        argmax_idx_d   = argmax_idx_q;
        argmax_valid_d = 1'b0;
        overrun_d      = overrun_q;

        // Argmax candidate is the beat being transferred now; beat 0 seeded
        // best at capture, so only later beats compete. Strict '>' keeps the
        // lowest index on ties.
        nxt_idx    = idx_q + 1'b1;
        cand       = $signed(snap_q[idx_q]);
        take       = (idx_q != '0) && (cand > best_q);
        best_n     = take ? cand  : best_q;
        best_idx_n = take ? idx_q : best_idx_q;

        case (state_q)
            S_IDLE: begin
                if (layer_done) begin
                    snap_d     = layer_out;
                    idx_d      = '0;
                    best_d     = $signed(layer_out[0]);
                    best_idx_d = '0;
                    m_valid_d  = 1'b1;
                    m_data_d   = relu_f(layer_out[0]);
                    m_last_d   = 1'b0;
                    state_d    = S_STREAM;
                end
            end
            S_STREAM: begin
                if (layer_done) overrun_d = 1'b1;
                if (xfer) begin
                    best_d     = best_n;
                    best_idx_d = best_idx_n;
                    if (m_last_q) begin
                        // Report the result including the final beat.
                        m_valid_d      = 1'b0;
                        m_last_d       = 1'b0;
                        argmax_idx_d   = best_idx_n;
                        argmax_valid_d = 1'b1;
                        state_d        = S_REPORT;
                    end else begin
                        idx_d    = nxt_idx;
                        m_data_d = relu_f(snap_q[nxt_idx]);
                        m_last_d = (nxt_idx == LAST_IDX);
                    end
                end
            end
            S_REPORT: begin
                if (layer_done) overrun_d = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            snap_q         <= '0;
            idx_q          <= '0;
            best_q         <= '0;
            best_idx_q     <= '0;
            m_valid_q      <= 1'b0;
            m_data_q       <= '0;
            m_last_q       <= 1'b0;
            argmax_idx_q   <= '0;
            argmax_valid_q <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            snap_q         <= snap_d;
            idx_q          <= idx_d;
            best_q         <= best_d;
            best_idx_q     <= best_idx_d;
            m_valid_q      <= m_valid_d;
            m_data_q       <= m_data_d;
            m_last_q       <= m_last_d;
            argmax_idx_q   <= argmax_idx_d;
            argmax_valid_q <= argmax_valid_d;
            overrun_q      <= overrun_d;
        end
    end

    assign m.m_valid    = m_valid_q;
    assign m.m_data     = m_data_q;
    assign m.m_index    = idx_q;
    assign m.m_last     = m_last_q;
    assign busy         = (state_q != S_IDLE);
    assign argmax_idx   = argmax_idx_q;
    assign argmax_valid = argmax_valid_q;
    assign overrun      = overrun_q;
endmodule
